// File: rtl/pipe_mux_n.sv
// Registered N-way source mux with a constant slot, illegal-select tracking
// and a 2-entry (head + skid) valid/ready output buffer.
module pipe_mux_n #(
  parameter int          WIDTH     = 32,
  parameter int          N_IN      = 6,
  parameter int          SEL_W     = 3,
  parameter int unsigned CONST_VAL = 227,
  parameter int          ERRCNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERRCNT_W-1:0]     err_cnt,
  input  logic                    err_clr
);

  localparam logic [WIDTH-1:0] CONST_WORD = WIDTH'(CONST_VAL);

  logic [1:0]       occ_p1;
  logic [WIDTH-1:0] headData_p1;
  logic [WIDTH-1:0] skidData_p1;
  logic [WIDTH-1:0] selData_p0;
  logic             selIllegal_p0;
  logic             accept;
  logic             pop;

  function automatic logic [ERRCNT_W-1:0] satInc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage 0: source selection, constant slot and illegal-select decode
  always_comb begin
    selData_p0 = CONST_WORD;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) selData_p0 = in_bus[k*WIDTH +: WIDTH];
    end
  end

  assign selIllegal_p0 = (int'(sel) > N_IN);

  // Handshake depends only on registered occupancy, so out_ready never reaches in_ready
  assign in_ready  = (occ_p1 < 2'd2);
  assign out_valid = (occ_p1 != 2'd0);
  assign out_data  = headData_p1;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Stage 1: head/skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_p1      <= 2'd0;
      headData_p1 <= '0;
      skidData_p1 <= '0;
    end else begin
      unique case (occ_p1)
        2'd0: begin
          if (accept) begin
            headData_p1 <= selData_p0;
            occ_p1      <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            headData_p1 <= selData_p0;
          end else if (accept) begin
            skidData_p1 <= selData_p0;
            occ_p1      <= 2'd2;
          end else if (pop) begin
            occ_p1      <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            headData_p1 <= skidData_p1;
            occ_p1      <= 2'd1;
          end
        end
      endcase
    end
  end

  // Error tracking: an accepted illegal select takes priority over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else if (accept && selIllegal_p0) begin
      sel_err <= 1'b1;
      err_cnt <= err_clr ? ERRCNT_W'(1) : satInc(err_cnt);
    end else if (err_clr) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed bench for pipe_mux_n: vector table for selection/error basics,
// hand-written sequences for stall, streaming, saturation and async reset.
module tb_pipe_mux_n;

  localparam int WIDTH = 32;
  localparam int N_IN  = 6;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_IN*WIDTH-1:0] inBus;
  logic [2:0]            sel;
  logic                  inValid;
  logic                  inReady;
  logic [WIDTH-1:0]      outData;
  logic                  outValid;
  logic                  outReady;
  logic                  selErr;
  logic [7:0]            errCnt;
  logic                  errClr;

  int checks = 0;
  int errors = 0;

  pipe_mux_n #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(3), .CONST_VAL(227), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(inBus), .sel(sel), .in_valid(inValid),
    .in_ready(inReady), .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .sel_err(selErr), .err_cnt(errCnt), .err_clr(errClr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        inValid;
    logic        outReady;
    logic        errClr;
    logic [31:0] expData;
    logic        expValid;
    logic        expReady;
    logic        expErr;
    logic [7:0]  expCnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input int k, input logic [31:0] v);
    inBus[k*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    rst_n = 1'b0; inBus = '0; sel = '0; inValid = 1'b0; outReady = 1'b0; errClr = 1'b0;
    for (int k = 0; k < N_IN; k++) setIn(k, 32'h100 + k);

    for (int k = 0; k < 6; k++)
      vecs[k] = '{3'(k), 1'b1, 1'b1, 1'b0, 32'h100 + k, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[6] = '{3'd6, 1'b1, 1'b1, 1'b0, 32'd227, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[7] = '{3'd7, 1'b1, 1'b1, 1'b0, 32'd227, 1'b1, 1'b1, 1'b1, 8'd1};
    vecs[8] = '{3'd7, 1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 8'd1};
    vecs[9] = '{3'd7, 1'b0, 1'b1, 1'b1, 32'd0,   1'b0, 1'b1, 1'b0, 8'd0};

    #12;
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_ready", 32'(inReady), 32'd1);
    chk("rst_data", outData, 32'd0);
    chk("rst_err", 32'(selErr), 32'd0);
    chk("rst_cnt", 32'(errCnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Vector table: select sweep, constant slot, illegal select, clear
    for (int i = 0; i < 10; i++) begin
      sel = vecs[i].sel; inValid = vecs[i].inValid;
      outReady = vecs[i].outReady; errClr = vecs[i].errClr;
      tick();
      if (vecs[i].expValid) chk($sformatf("vec%0d_data", i), outData, vecs[i].expData);
      chk($sformatf("vec%0d_valid", i), 32'(outValid), 32'(vecs[i].expValid));
      chk($sformatf("vec%0d_ready", i), 32'(inReady), 32'(vecs[i].expReady));
      chk($sformatf("vec%0d_err", i), 32'(selErr), 32'(vecs[i].expErr));
      chk($sformatf("vec%0d_cnt", i), 32'(errCnt), 32'(vecs[i].expCnt));
    end
    errClr = 1'b0;

    // Stall: A, B accepted, C held off, then drained in order
    outReady = 1'b0; inValid = 1'b1; sel = 3'd0; setIn(0, 32'hA);
    tick();
    chk("stall_a_data", outData, 32'hA);
    chk("stall_a_ready", 32'(inReady), 32'd1);
    setIn(0, 32'hB);
    tick();
    chk("stall_b_data", outData, 32'hA);
    chk("stall_b_ready", 32'(inReady), 32'd0);
    setIn(0, 32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_data", outData, 32'hA);
      chk("stall_hold_ready", 32'(inReady), 32'd0);
    end
    outReady = 1'b1;
    tick();
    chk("drain_b", outData, 32'hB);
    chk("drain_b_ready", 32'(inReady), 32'd1);
    tick();
    chk("drain_c", outData, 32'hC);
    chk("drain_c_valid", 32'(outValid), 32'd1);
    inValid = 1'b0;
    tick();
    chk("drain_empty", 32'(outValid), 32'd0);

    // Streaming at occupancy 1: accept + pop every cycle
    inValid = 1'b1; sel = 3'd1; setIn(1, 32'h1FF);
    tick();
    for (int i = 0; i < 10; i++) begin
      setIn(1, 32'h200 + i);
      tick();
      chk($sformatf("stream%0d_data", i), outData, 32'h200 + i);
      chk($sformatf("stream%0d_ready", i), 32'(inReady), 32'd1);
    end
    inValid = 1'b0;
    tick();
    setIn(1, 32'h101);

    // Saturation, then clear concurrent with an illegal accept
    inValid = 1'b1; sel = 3'd7; outReady = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("sat_cnt", 32'(errCnt), 32'd255);
    chk("sat_err", 32'(selErr), 32'd1);
    errClr = 1'b1;
    tick();
    chk("clr_set_cnt", 32'(errCnt), 32'd1);
    chk("clr_set_err", 32'(selErr), 32'd1);
    errClr = 1'b0; inValid = 1'b0;
    tick();

    // Illegal select not accepted while full has no effect
    outReady = 1'b0; inValid = 1'b1; sel = 3'd2;
    tick(); tick();
    chk("full_ready", 32'(inReady), 32'd0);
    sel = 3'd7;
    tick(); tick();
    chk("noacc_cnt", 32'(errCnt), 32'd1);
    chk("full_head", outData, 32'h102);

    // Async reset with occupancy 2, mid-cycle
    inValid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(outValid), 32'd0);
    chk("arst_ready", 32'(inReady), 32'd1);
    chk("arst_data", outData, 32'd0);
    chk("arst_cnt", 32'(errCnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", 32'(outValid), 32'd0);
      chk("post_rst_ready", 32'(inReady), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
